// File: rtl/dcache_line_engine_if.sv
// Bundle of the engine's request, SRAM and memory-bus signals.
// slave = line engine side, master = cache controller / SRAM / memory side.
interface dcache_line_engine_if #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = 4,
  parameter int LINE_WORDS     = 8,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int SET_WIDTH      = ADDR_WIDTH - $clog2(LINE_WORDS)
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_wb;
  logic [SET_WIDTH-1:0]      req_set;
  logic [MEM_ADDR_WIDTH-1:0] req_wb_addr;
  logic [MEM_ADDR_WIDTH-1:0] req_fill_addr;
  logic                      done;
  logic                      done_err;
  logic                      sram_wr_en;
  logic [ADDR_WIDTH-1:0]     sram_wr_addr;
  logic [DATA_WIDTH-1:0]     sram_wr_data;
  logic [BE_WIDTH-1:0]       sram_wr_byte_en;
  logic [ADDR_WIDTH-1:0]     sram_rd_addr;
  logic [DATA_WIDTH-1:0]     sram_rd_data;
  logic                      mem_cmd_valid;
  logic                      mem_cmd_ready;
  logic                      mem_cmd_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_cmd_addr;
  logic                      mem_wdata_valid;
  logic                      mem_wdata_ready;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic                      mem_wdata_last;
  logic                      mem_rdata_valid;
  logic                      mem_rdata_ready;
  logic [DATA_WIDTH-1:0]     mem_rdata;
  logic                      mem_rdata_last;

  modport slave (
    input  req_valid, req_wb, req_set, req_wb_addr, req_fill_addr,
    output req_ready, done, done_err,
    output sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_byte_en, sram_rd_addr,
    input  sram_rd_data,
    output mem_cmd_valid, mem_cmd_we, mem_cmd_addr,
    input  mem_cmd_ready,
    output mem_wdata_valid, mem_wdata, mem_wdata_last,
    input  mem_wdata_ready,
    input  mem_rdata_valid, mem_rdata, mem_rdata_last,
    output mem_rdata_ready
  );

  modport master (
    output req_valid, req_wb, req_set, req_wb_addr, req_fill_addr,
    input  req_ready, done, done_err,
    input  sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_byte_en, sram_rd_addr,
    output sram_rd_data,
    input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr,
    output mem_cmd_ready,
    input  mem_wdata_valid, mem_wdata, mem_wdata_last,
    output mem_wdata_ready,
    output mem_rdata_valid, mem_rdata, mem_rdata_last,
    input  mem_rdata_ready
  );
endinterface

// File: rtl/dcache_line_engine.sv
// Data-cache line engine: optional dirty-line write-back from the data SRAM to
// memory, then a burst refill written back into the SRAM, one request at a time.
module dcache_line_engine #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = 4,
  parameter int LINE_WORDS     = 8,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int SET_WIDTH      = ADDR_WIDTH - $clog2(LINE_WORDS)
) (
  input logic clk,
  input logic rst_n,
  dcache_line_engine_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] ALL_BEATS = CNT_W'(LINE_WORDS);

  typedef enum logic [2:0] {IDLE, WB_CMD, WB_DATA, FILL_CMD, FILL_DATA, DONE} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          beat_q, beat_d;
  logic                      err_q, err_d;
  logic [SET_WIDTH-1:0]      set_q;
  logic [MEM_ADDR_WIDTH-1:0] wb_addr_q, fill_addr_q;
  logic                      wr_en_q;
  logic [ADDR_WIDTH-1:0]     wr_addr_q;
  logic [DATA_WIDTH-1:0]     wr_data_q;
  logic                      req_hs, rd_hs;
  logic [OFF_W-1:0]          rd_off;

  always_comb begin
    state_d              = state_q;
    beat_d               = beat_q;
    err_d                = err_q;
    req_hs               = 1'b0;
    rd_hs                = 1'b0;
    rd_off               = '0;
    bus.req_ready        = 1'b0;
    bus.done             = 1'b0;
    bus.done_err         = 1'b0;
    bus.sram_rd_addr     = '0;
    bus.mem_cmd_valid    = 1'b0;
    bus.mem_cmd_we       = 1'b0;
    bus.mem_cmd_addr     = '0;
    bus.mem_wdata_valid  = 1'b0;
    bus.mem_wdata        = '0;
    bus.mem_wdata_last   = 1'b0;
    bus.mem_rdata_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        req_hs        = bus.req_valid;
        err_d         = 1'b0;
        if (req_hs) state_d = bus.req_wb ? WB_CMD : FILL_CMD;
      end
      WB_CMD: begin
        bus.mem_cmd_valid = 1'b1;
        bus.mem_cmd_we    = 1'b1;
        bus.mem_cmd_addr  = wb_addr_q;
        bus.sram_rd_addr  = {set_q, {OFF_W{1'b0}}};
        if (bus.mem_cmd_ready) begin
          beat_d  = '0;
          state_d = WB_DATA;
        end
      end
      WB_DATA: begin
        // Look one word ahead on an accepted beat so the SRAM's 1-cycle read
        // latency never inserts a bubble; on a stall the address and data hold.
        bus.mem_wdata_valid = 1'b1;
        bus.mem_wdata       = bus.sram_rd_data;
        bus.mem_wdata_last  = (beat_q == LAST_BEAT);
        rd_off              = beat_q[OFF_W-1:0] + OFF_W'(bus.mem_wdata_ready);
        bus.sram_rd_addr    = {set_q, rd_off};
        if (bus.mem_wdata_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = FILL_CMD;
        end
      end
      FILL_CMD: begin
        bus.mem_cmd_valid = 1'b1;
        bus.mem_cmd_addr  = fill_addr_q;
        if (bus.mem_cmd_ready) begin
          beat_d  = '0;
          state_d = FILL_DATA;
        end
      end
      FILL_DATA: begin
        // Once every beat is in, the final SRAM write is on the port this cycle.
        if (beat_q != ALL_BEATS) begin
          bus.mem_rdata_ready = 1'b1;
          rd_hs               = bus.mem_rdata_valid;
          if (rd_hs) begin
            beat_d = beat_q + 1'b1;
            if (bus.mem_rdata_last != (beat_q == LAST_BEAT)) err_d = 1'b1;
          end
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.done     = 1'b1;
        bus.done_err = err_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      err_q       <= 1'b0;
      set_q       <= '0;
      wb_addr_q   <= '0;
      fill_addr_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      wr_en_q <= rd_hs;
      if (req_hs) begin
        set_q       <= bus.req_set;
        wb_addr_q   <= bus.req_wb_addr;
        fill_addr_q <= bus.req_fill_addr;
      end
      if (rd_hs) begin
        wr_addr_q <= {set_q, beat_q[OFF_W-1:0]};
        wr_data_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.sram_wr_en      = wr_en_q;
  assign bus.sram_wr_addr    = wr_addr_q;
  assign bus.sram_wr_data    = wr_data_q;
  assign bus.sram_wr_byte_en = {BE_WIDTH{wr_en_q}};
endmodule

// File: tb/tb_dcache_line_engine.sv
// Directed bench for dcache_line_engine with a behavioural SRAM and memory model.
module tb_dcache_line_engine;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_pass = 0, n_total = 0;

  dcache_line_engine_if bus ();
  dcache_line_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: byte-enabled write, registered (1-cycle) read
  logic [31:0] sram [512];
  always @(posedge clk) begin
    if (bus.sram_wr_en)
      for (int b = 0; b < 4; b++)
        if (bus.sram_wr_byte_en[b]) sram[bus.sram_wr_addr][b*8 +: 8] <= bus.sram_wr_data[b*8 +: 8];
    bus.sram_rd_data <= sram[bus.sram_rd_addr];
  end

  // memory model knobs (written by the stimulus process only)
  logic [31:0] fill_base = 32'h0;
  int          err_beat  = -1;
  logic [3:0]  wr_pat    = 4'hF;
  int          stray_req = 0;

  // logs (written by the memory/monitor process only)
  logic [8:0]  wl_addr[$];
  logic [31:0] wl_data[$];
  logic [3:0]  wl_be[$];
  int          wl_cyc[$];
  logic [31:0] cl_addr[$];
  bit          cl_we[$];
  int          cl_cyc[$];
  logic [31:0] wb_data[$];
  bit          wb_last[$];
  int          wb_cyc[$];
  int          done_cnt = 0, done_cyc = 0, stall_bad = 0, stray_ack = 0, rd_idx = 0, ph = 0;
  bit          done_err_s, stall_prev, cmd_hs, cmd_we, wd_hs, rd_hs, rd_act;
  logic [31:0] wd_prev;

  initial begin
    bus.mem_cmd_ready   = 1'b1;
    bus.mem_wdata_ready = 1'b1;
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = '0;
    bus.mem_rdata_last  = 1'b0;
    rd_act = 0;
    forever begin
      @(negedge clk);
      if (bus.sram_wr_en) begin
        wl_addr.push_back(bus.sram_wr_addr); wl_data.push_back(bus.sram_wr_data);
        wl_be.push_back(bus.sram_wr_byte_en); wl_cyc.push_back(cyc);
      end
      if (bus.done) begin done_cnt++; done_cyc = cyc; done_err_s = bus.done_err; end
      if (stall_prev && bus.mem_wdata_valid && bus.mem_wdata !== wd_prev) stall_bad++;
      stall_prev = bus.mem_wdata_valid && !bus.mem_wdata_ready;
      wd_prev    = bus.mem_wdata;
      cmd_hs = bus.mem_cmd_valid && bus.mem_cmd_ready;
      cmd_we = bus.mem_cmd_we;
      if (cmd_hs) begin cl_addr.push_back(bus.mem_cmd_addr); cl_we.push_back(cmd_we); cl_cyc.push_back(cyc); end
      wd_hs = bus.mem_wdata_valid && bus.mem_wdata_ready;
      if (wd_hs) begin wb_data.push_back(bus.mem_wdata); wb_last.push_back(bus.mem_wdata_last); wb_cyc.push_back(cyc); end
      rd_hs = bus.mem_rdata_valid && bus.mem_rdata_ready;
      @(posedge clk); #1;
      if (!rst_n) begin
        rd_act = 0; rd_idx = 0;
      end else begin
        if (cmd_hs && !cmd_we) begin rd_act = 1; rd_idx = 0; end
        else if (rd_hs) rd_idx++;
        if (rd_idx == LW) rd_act = 0;
      end
      ph = (ph + 1) % 4;
      bus.mem_wdata_ready = wr_pat[ph];
      if (rd_act) begin
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata       = fill_base + 32'(rd_idx);
        bus.mem_rdata_last  = (rd_idx == err_beat) || (rd_idx == LW - 1);
      end else if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata       = 32'hDEAD_BEEF;
        bus.mem_rdata_last  = 1'b1;
      end else begin
        bus.mem_rdata_valid = 1'b0;
        bus.mem_rdata_last  = 1'b0;
      end
    end
  end

  // stimulus drivers, entered and left at posedge+1
  task automatic send_req(input logic wb, input logic [5:0] set, input logic [31:0] wa, input logic [31:0] fa);
    bus.req_valid = 1'b1; bus.req_wb = wb; bus.req_set = set;
    bus.req_wb_addr = wa; bus.req_fill_addr = fa;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.req_ready, bus.done, bus.done_err, bus.sram_wr_en, bus.mem_cmd_valid, bus.mem_wdata_valid, bus.mem_rdata_ready} !== 7'b1000000)
      $display("FAIL reset_ctrl: got %b exp 1000000", {bus.req_ready, bus.done, bus.done_err, bus.sram_wr_en,
               bus.mem_cmd_valid, bus.mem_wdata_valid, bus.mem_rdata_ready});
    else n_pass++;
    n_total++;
    if ({bus.sram_rd_addr, bus.sram_wr_addr, bus.sram_wr_byte_en, bus.mem_cmd_addr, bus.mem_wdata} !== '0)
      $display("FAIL reset_data: rd_addr %h wr_addr %h be %h cmd_addr %h wdata %h exp all 0", bus.sram_rd_addr,
               bus.sram_wr_addr, bus.sram_wr_byte_en, bus.mem_cmd_addr, bus.mem_wdata);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_refill();
    int w0, c0; bit ok;
    w0 = wl_addr.size(); c0 = cl_addr.size();
    fill_base = 32'hA0; err_beat = -1;
    send_req(1'b0, 6'd3, 32'h0, 32'h1000);
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL refill_done: done not seen within bound"); else n_pass++;
    n_total++;
    if (wl_addr.size() - w0 != LW) $display("FAIL refill_count: got %0d writes exp 8", wl_addr.size() - w0);
    else n_pass++;
    if (wl_addr.size() - w0 == LW) begin
      for (int i = 0; i < LW; i++) begin
        n_total++;
        if ({wl_addr[w0+i], wl_data[w0+i], wl_be[w0+i]} !== {9'(24 + i), 32'hA0 + 32'(i), 4'hF})
          $display("FAIL refill_word%0d: addr %0d data %h be %h exp addr %0d data %h be f", i, wl_addr[w0+i],
                   wl_data[w0+i], wl_be[w0+i], 24 + i, 32'hA0 + i);
        else n_pass++;
      end
      n_total++;
      if (done_cyc != wl_cyc[w0+LW-1] + 1)
        $display("FAIL refill_done_timing: done at cycle %0d exp %0d", done_cyc, wl_cyc[w0+LW-1] + 1);
      else n_pass++;
    end
    n_total++; if (done_err_s !== 1'b0) $display("FAIL refill_done_err: got %b exp 0", done_err_s); else n_pass++;
    n_total++;
    if (cl_addr.size() - c0 != 1 || cl_addr[c0] !== 32'h1000 || cl_we[c0] !== 1'b0)
      $display("FAIL refill_cmd: %0d cmds, addr %h we %b exp 1 cmd addr 1000 we 0", cl_addr.size() - c0, cl_addr[c0], cl_we[c0]);
    else n_pass++;
  endtask

  task automatic test_wb_refill();
    int w0, c0, b0; bit ok;
    fill_base = 32'h100; err_beat = -1;
    send_req(1'b0, 6'd7, 32'h0, 32'h5000);
    wait_done(ok);
    w0 = wl_addr.size(); c0 = cl_addr.size(); b0 = wb_data.size();
    fill_base = 32'h200;
    send_req(1'b1, 6'd7, 32'h2000, 32'h3000);
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL wb_done: done not seen within bound"); else n_pass++;
    n_total++;
    if (wb_data.size() - b0 != LW) $display("FAIL wb_count: got %0d beats exp 8", wb_data.size() - b0);
    else n_pass++;
    if (wb_data.size() - b0 == LW)
      for (int i = 0; i < LW; i++) begin
        n_total++;
        if (wb_data[b0+i] !== 32'h100 + 32'(i) || wb_last[b0+i] !== (i == LW - 1) || wb_cyc[b0+i] != wb_cyc[b0] + i)
          $display("FAIL wb_beat%0d: data %h last %b cyc %0d exp data %h last %b cyc %0d", i, wb_data[b0+i],
                   wb_last[b0+i], wb_cyc[b0+i], 32'h100 + i, i == LW - 1, wb_cyc[b0] + i);
        else n_pass++;
      end
    n_total++;
    if (cl_addr.size() - c0 != 2 || cl_addr[c0] !== 32'h2000 || cl_we[c0] !== 1'b1 ||
        cl_addr[c0+1] !== 32'h3000 || cl_we[c0+1] !== 1'b0)
      $display("FAIL wb_cmds: %0d cmds, %h/%b then %h/%b exp 2000/1 then 3000/0", cl_addr.size() - c0,
               cl_addr[c0], cl_we[c0], cl_addr[c0+1], cl_we[c0+1]);
    else n_pass++;
    n_total++;
    if (wb_data.size() - b0 == LW && cl_cyc[c0+1] <= wb_cyc[b0+LW-1])
      $display("FAIL wb_order: read cmd at cycle %0d not after last wb beat %0d", cl_cyc[c0+1], wb_cyc[b0+LW-1]);
    else n_pass++;
    n_total++;
    if (wl_addr.size() - w0 != LW || wl_addr[w0] !== 9'd56 || wl_data[w0] !== 32'h200 ||
        wl_addr[w0+LW-1] !== 9'd63 || wl_data[w0+LW-1] !== 32'h207)
      $display("FAIL wb_refill_writes: %0d writes, first %0d/%h last %0d/%h exp 8, 56/200, 63/207", wl_addr.size() - w0,
               wl_addr[w0], wl_data[w0], wl_addr[w0+LW-1], wl_data[w0+LW-1]);
    else n_pass++;
  endtask

  task automatic test_wb_backpressure();
    int b0, s0; bit ok;
    fill_base = 32'h300;
    send_req(1'b0, 6'd5, 32'h0, 32'h6000);
    wait_done(ok);
    b0 = wb_data.size(); s0 = stall_bad;
    wr_pat = 4'b1001;
    fill_base = 32'h400;
    send_req(1'b1, 6'd5, 32'h7000, 32'h8000);
    wait_done(ok);
    wr_pat = 4'hF;
    n_total++; if (!ok) $display("FAIL bp_done: done not seen within bound"); else n_pass++;
    n_total++; if (stall_bad != s0) $display("FAIL bp_stable: %0d wdata changes while stalled exp 0", stall_bad - s0); else n_pass++;
    n_total++;
    if (wb_data.size() - b0 != LW) $display("FAIL bp_count: got %0d beats exp 8", wb_data.size() - b0);
    else n_pass++;
    if (wb_data.size() - b0 == LW) begin
      for (int i = 0; i < LW; i++) begin
        n_total++;
        if (wb_data[b0+i] !== 32'h300 + 32'(i) || wb_last[b0+i] !== (i == LW - 1))
          $display("FAIL bp_beat%0d: data %h last %b exp data %h last %b", i, wb_data[b0+i], wb_last[b0+i],
                   32'h300 + i, i == LW - 1);
        else n_pass++;
      end
      n_total++;
      if (wb_cyc[b0+LW-1] - wb_cyc[b0] <= LW - 1)
        $display("FAIL bp_stalled: burst spanned %0d cycles exp more than 7", wb_cyc[b0+LW-1] - wb_cyc[b0]);
      else n_pass++;
    end
  endtask

  task automatic test_last_err();
    int w0; bit ok;
    w0 = wl_addr.size();
    fill_base = 32'h500; err_beat = 5;
    send_req(1'b0, 6'd2, 32'h0, 32'h9000);
    wait_done(ok);
    err_beat = -1;
    n_total++; if (!ok || done_err_s !== 1'b1) $display("FAIL lasterr_flag: done %b done_err %b exp 1 1", ok, done_err_s); else n_pass++;
    n_total++;
    if (wl_addr.size() - w0 != LW || wl_addr[w0+LW-1] !== 9'd23 || wl_data[w0+LW-1] !== 32'h507)
      $display("FAIL lasterr_writes: %0d writes, last %0d/%h exp 8, 23/507", wl_addr.size() - w0,
               wl_addr[w0+LW-1], wl_data[w0+LW-1]);
    else n_pass++;
    fill_base = 32'h600;
    send_req(1'b0, 6'd2, 32'h0, 32'h9000);
    wait_done(ok);
    n_total++; if (!ok || done_err_s !== 1'b0) $display("FAIL lasterr_clear: done %b done_err %b exp 1 0", ok, done_err_s); else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    int w0, w1; bit ok;
    w0 = wl_addr.size();
    fill_base = 32'h700;
    send_req(1'b0, 6'd4, 32'h0, 32'h4000);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (rd_idx >= 3) begin ok = 1; break; end
    end
    n_total++; if (!ok) $display("FAIL rstmid_beats: 3 fill beats not seen within bound"); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.sram_wr_en, bus.req_ready, bus.mem_rdata_ready, bus.mem_cmd_valid, bus.done} !== 5'b01000)
      $display("FAIL rstmid_outputs: wr_en/ready/rdata_ready/cmd_valid/done %b exp 01000",
               {bus.sram_wr_en, bus.req_ready, bus.mem_rdata_ready, bus.mem_cmd_valid, bus.done});
    else n_pass++;
    w1 = wl_addr.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (w1 - w0 != 2 || wl_addr.size() != w1)
      $display("FAIL rstmid_writes: %0d writes before reset, %0d after, exp 2 and 0", w1 - w0, wl_addr.size() - w1);
    else n_pass++;
    fill_base = 32'h800;
    send_req(1'b0, 6'd4, 32'h0, 32'h4000);
    wait_done(ok);
    n_total++;
    if (!ok || done_err_s !== 1'b0 || wl_addr.size() - w1 != LW || wl_addr[w1] !== 9'd32 || wl_data[w1+LW-1] !== 32'h807)
      $display("FAIL rstmid_recover: done %b err %b writes %0d first addr %0d last data %h exp 1 0 8 32 807",
               ok, done_err_s, wl_addr.size() - w1, wl_addr[w1], wl_data[w1+LW-1]);
    else n_pass++;
  endtask

  task automatic test_busy_stray();
    int w0, c0, d0; bit ok, seen;
    w0 = wl_addr.size(); c0 = cl_addr.size(); d0 = done_cnt;
    fill_base = 32'h900;
    send_req(1'b0, 6'd1, 32'h0, 32'hA000);
    bus.req_valid = 1'b1; bus.req_wb = 1'b1; bus.req_set = 6'd6;
    wait_done(ok);
    bus.req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    if (!ok || cl_addr.size() - c0 != 1 || done_cnt - d0 != 1 || bus.req_ready !== 1'b1)
      $display("FAIL busy_ignored: done %b cmds %0d dones %0d ready %b exp 1 1 1 1", ok, cl_addr.size() - c0,
               done_cnt - d0, bus.req_ready);
    else n_pass++;
    n_total++;
    if (wl_addr.size() - w0 != LW || wl_addr[w0] !== 9'd8 || wl_addr[w0+LW-1] !== 9'd15)
      $display("FAIL busy_writes: %0d writes first %0d last %0d exp 8 8 15", wl_addr.size() - w0,
               wl_addr[w0], wl_addr[w0+LW-1]);
    else n_pass++;
    w0 = wl_addr.size();
    stray_req++;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_rdata_valid) begin
        seen = 1;
        n_total++;
        if (bus.mem_rdata_ready !== 1'b0) $display("FAIL stray_ready: got %b exp 0", bus.mem_rdata_ready);
        else n_pass++;
        break;
      end
    end
    repeat (4) @(posedge clk);
    #1;
    n_total++;
    if (!seen || wl_addr.size() != w0)
      $display("FAIL stray_write: pulse seen %b, %0d SRAM writes exp 1 and 0", seen, wl_addr.size() - w0);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_wb = 1'b0; bus.req_set = '0;
    bus.req_wb_addr = '0; bus.req_fill_addr = '0;
    test_reset();
    test_refill();
    test_wb_refill();
    test_wb_backpressure();
    test_last_err();
    test_reset_mid_fill();
    test_busy_stray();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dcache_line_engine.md
Name: dcache_line_engine

Overview:
- Line refill / write-back engine for the data cache. It sits directly in front of the DCACHE_SRAM1 data array (512x32, byte-enabled, 1-cycle unregistered read) and owns that SRAM's write port and read port during line transfers.
- On a miss it can first stream a dirty line from the SRAM out to the memory bus, then burst-read the new line and write it into the SRAM.
- The cache controller hands it one request at a time and gets a done pulse back.

Parameters:
- ADDR_WIDTH, 9, SRAM word address width.
- DATA_WIDTH, 32, SRAM/memory data width.
- BE_WIDTH, 4, SRAM byte-enable width (DATA_WIDTH/8).
- LINE_WORDS, 8, words per cache line; must be a power of 2, 2..64.
- MEM_ADDR_WIDTH, 32, memory byte address width.
- SET_WIDTH, ADDR_WIDTH-log2(LINE_WORDS), line index width (derived).

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  engine idle; request accepted when req_valid && req_ready.
- req_wb  in  1  1 = write back the old line before the refill.
- req_set  in  SET_WIDTH  SRAM line index.
- req_wb_addr  in  MEM_ADDR_WIDTH  memory byte address of the victim line.
- req_fill_addr  in  MEM_ADDR_WIDTH  memory byte address of the new line.
- done  out  1  one-cycle pulse when the request completes.
- done_err  out  1  valid with done; a fill last-beat mismatch occurred.
- sram_wr_en  out  1  SRAM write enable.
- sram_wr_addr  out  ADDR_WIDTH  SRAM write address.
- sram_wr_data  out  DATA_WIDTH  SRAM write data.
- sram_wr_byte_en  out  BE_WIDTH  SRAM byte enables.
- sram_rd_addr  out  ADDR_WIDTH  SRAM read address (combinational).
- sram_rd_data  in  DATA_WIDTH  SRAM read data, 1 cycle after the address.
- mem_cmd_valid  out  1  memory command valid.
- mem_cmd_ready  in  1  memory command accept.
- mem_cmd_we  out  1  1 = write burst, 0 = read burst.
- mem_cmd_addr  out  MEM_ADDR_WIDTH  burst base byte address.
- mem_wdata_valid  out  1  write beat valid.
- mem_wdata_ready  in  1  write beat accept.
- mem_wdata  out  DATA_WIDTH  write beat data.
- mem_wdata_last  out  1  final write beat.
- mem_rdata_valid  in  1  read beat valid.
- mem_rdata_ready  out  1  read beat accept.
- mem_rdata  in  DATA_WIDTH  read beat data.
- mem_rdata_last  in  1  final read beat flag.

Behaviour:
- Reset values: all outputs 0 except req_ready=1. State IDLE, beat counter 0, error flag 0.
- Request capture:
  - On handshake in IDLE, capture req_wb, req_set and both addresses.
  - Line base word address base = {req_set, log2(LINE_WORDS) zeros}.
- States: IDLE, WB_CMD, WB_DATA, FILL_CMD, FILL_DATA, DONE.
  - IDLE -> WB_CMD if req_wb=1, else FILL_CMD.
  - WB_CMD -> WB_DATA on cmd handshake.
  - WB_DATA -> FILL_CMD after the last beat is accepted.
  - FILL_CMD -> FILL_DATA on cmd handshake.
  - FILL_DATA -> DONE after LINE_WORDS beats have been accepted and the final SRAM write has been issued.
  - DONE -> IDLE after one cycle.
- req_ready=1 only in IDLE.
- WB_CMD: mem_cmd_valid=1, mem_cmd_we=1, mem_cmd_addr=wb_addr, sram_rd_addr=base. Because WB_CMD lasts at least one cycle, word 0 is already on sram_rd_data when WB_DATA is entered.
- WB_DATA:
  - mem_wdata_valid=1; mem_wdata=sram_rd_data.
  - sram_rd_addr = base + beat + (beat handshake ? 1 : 0), computed combinationally, so streaming runs at 1 beat/cycle with no bubble.
  - When mem_wdata_ready is low the address holds, so the data holds.
  - mem_wdata_last=1 when beat=LINE_WORDS-1.
- FILL_CMD: mem_cmd_valid=1, mem_cmd_we=0, mem_cmd_addr=fill_addr.
- FILL_DATA:
  - mem_rdata_ready=1 until LINE_WORDS beats have been accepted, then 0.
  - Each accepted beat k produces a registered SRAM write on the next cycle: sram_wr_en=1, sram_wr_addr=base+k, sram_wr_data=mem_rdata, sram_wr_byte_en=all 1s.
  - sram_wr_en is 0 at all other times.
- Beat counter: log2(LINE_WORDS)+1 bits. It is cleared on entry to WB_DATA and FILL_DATA and increments on each accepted beat. Address offset arithmetic wraps within the line and never carries into the set bits.
- Last-beat check:
  - mem_rdata_last=1 on any beat other than LINE_WORDS-1, or 0 on beat LINE_WORDS-1, sets the error flag.
  - Termination is governed only by the beat count.
  - done_err = error flag during DONE; the flag clears on return to IDLE.
- done: exactly 1 cycle, in DONE state, which is one cycle after the last SRAM write.
- Command stall: mem_cmd_valid, mem_cmd_we and mem_cmd_addr stay stable until accepted.
- Read beats: mem_rdata_valid outside FILL_DATA is ignored; it is not accepted and not written.
- req_valid while busy: ignored, no capture.
- Reset mid-transfer: asynchronous return to IDLE, all outputs go to reset values immediately, and no further SRAM write is issued.

Test Plan:
- Refill only:
  - Stimulus: req_wb=0, req_set=3, fill_addr=0x1000; memory returns 0xA0..0xA7 with ready always high.
  - Required: SRAM writes to addr 24..31 with data 0xA0..0xA7 and byte_en=4'hF; done 1 cycle after the write to addr 31; done_err=0.
- Write-back plus refill:
  - Stimulus: SRAM words 56..63 preloaded 0x100..0x107; req_wb=1, req_set=7, wb_addr=0x2000.
  - Required: write burst to 0x2000 carries 0x100..0x107 back-to-back with last on 0x107; then a read burst is issued to fill_addr and the refill lands in 56..63.
- Write-back backpressure:
  - Stimulus: mem_wdata_ready toggles 1,0,0,1 repeatedly.
  - Required: mem_wdata is stable while stalled; all 8 words are delivered in order with no duplicate or skip.
- Last-flag errors:
  - Stimulus: mem_rdata_last asserted on beat 5 of 8.
  - Required: all 8 beats are still written; done_err=1 with done. The next clean request gives done_err=0.
- Reset mid-fill:
  - Stimulus: rst_n dropped after 3 fill beats.
  - Required: sram_wr_en=0 and req_ready=1 immediately. The next request completes normally.
- Busy and stray traffic:
  - Stimulus: req_valid held high during a transfer; mem_rdata_valid pulsed while in IDLE.
  - Required: the busy request is not captured; the stray read beat produces no SRAM write and mem_rdata_ready stays 0.
